// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter for the single register-file write port; emits registered GNT, one-hot LOAD and shared D.
// Latency: request sampled at edge k drives GNT/LOAD/D during k..k+1, register captures D at edge k+1.
// Backpressure: a requester holds REQ until it sees GNT; just-granted requesters are masked for one edge.
// Optional build macro RF_ARB_LOCK_EN adds the LOCKED burst-hold state and burst counter.
module rf_write_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int MAX_BURST  = 4
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [NUM_REQ-1:0]            req_i,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] data_i,
   input  logic [NUM_REQ-1:0]            lock_i,
   output logic [NUM_REQ-1:0]            gnt_o,
   output logic [(2**ADDR_WIDTH)-1:0]    load_o,
   output logic [DATA_WIDTH-1:0]         d_o,
   output logic                          busy_o
);

   localparam int NREG  = 2**ADDR_WIDTH;
   localparam int PTR_W = $clog2(NUM_REQ);

`ifdef RF_ARB_LOCK_EN
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_GRANT = 2'd1, ST_LOCKED = 2'd2} state_t;
   localparam int BURST_W = $clog2(MAX_BURST + 1);
`else
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_GRANT = 2'd1} state_t;
`endif

   state_t                  state_q;
   logic [NUM_REQ-1:0]      gnt_q;
   logic [NREG-1:0]         load_q;
   logic [DATA_WIDTH-1:0]   d_q;
   logic                    busy_q;
   logic [PTR_W-1:0]        ptr_q;

   logic [NUM_REQ-1:0]      elig;
   logic                    win_vld;
   logic [PTR_W-1:0]        win_idx;
   logic                    hold_vld;
   logic                    sel_vld;
   logic [PTR_W-1:0]        sel_idx;
   logic [ADDR_WIDTH-1:0]   sel_addr;
   logic [NUM_REQ-1:0]      gnt_d;
   logic [NREG-1:0]         load_d;
   logic [DATA_WIDTH-1:0]   d_d;
   logic                    busy_d;
   logic [PTR_W-1:0]        ptr_d;

   // Round-robin search: first eligible requester at or after the pointer, wrapping.
   always_comb begin
      elig    = req_i & ~gnt_q;
      win_vld = 1'b0;
      win_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!win_vld && elig[(int'(ptr_q) + k) % NUM_REQ]) begin
            win_vld = 1'b1;
            win_idx = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
         end
      end
   end

`ifdef RF_ARB_LOCK_EN
   logic [BURST_W-1:0] burst_q;
   logic [PTR_W-1:0]   hold_idx;

   // Burst hold: the current holder keeps the port while REQ&LOCK and the burst budget remains.
   always_comb begin
      hold_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_q[i]) hold_idx = PTR_W'(i);
      end
      hold_vld = (state_q != ST_IDLE) && (|(gnt_q & req_i & lock_i)) &&
                 (int'(burst_q) < MAX_BURST);
   end

   // Burst counter: counts consecutive grants to the same locking requester.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)         burst_q <= '0;
      else if (hold_vld) burst_q <= burst_q + 1'b1;
      else if (win_vld)  burst_q <= BURST_W'(1);
      else               burst_q <= '0;
   end
`else
   logic lock_unused;
   localparam int UNUSED_MAX_BURST = MAX_BURST;
   assign lock_unused = ^lock_i;
   assign hold_vld    = 1'b0;
`endif

   // Next-state write controls from the selected requester; R0 never gets a load strobe.
   always_comb begin
      sel_vld = win_vld;
      sel_idx = win_idx;
`ifdef RF_ARB_LOCK_EN
      if (hold_vld) begin
         sel_vld = 1'b1;
         sel_idx = hold_idx;
      end
`endif
      sel_addr = addr_i[int'(sel_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      gnt_d    = '0;
      load_d   = '0;
      d_d      = d_q;
      if (sel_vld) begin
         gnt_d[sel_idx] = 1'b1;
         d_d            = data_i[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
         if (sel_addr != '0) load_d[sel_addr] = 1'b1;
      end
      busy_d = ($countones(elig) > 1);
      if (hold_vld) busy_d = |(req_i & ~gnt_q);
      // During a hold the pointer already sits at holder+1 from the holder's first grant.
      ptr_d = ptr_q;
      if (win_vld && !hold_vld) ptr_d = PTR_W'((int'(win_idx) + 1) % NUM_REQ);
   end

   // Arbiter FSM with registered grant, load, data and busy outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         load_q  <= '0;
         d_q     <= '0;
         busy_q  <= 1'b0;
         ptr_q   <= '0;
      end else begin
         gnt_q  <= gnt_d;
         load_q <= load_d;
         d_q    <= d_d;
         busy_q <= busy_d;
         ptr_q  <= ptr_d;
         case (state_q)
            ST_IDLE: begin
               if (sel_vld) state_q <= ST_GRANT;
            end
            ST_GRANT: begin
`ifdef RF_ARB_LOCK_EN
               if (hold_vld)     state_q <= ST_LOCKED;
               else if (win_vld) state_q <= ST_GRANT;
               else              state_q <= ST_IDLE;
`else
               if (win_vld) state_q <= ST_GRANT;
               else         state_q <= ST_IDLE;
`endif
            end
`ifdef RF_ARB_LOCK_EN
            ST_LOCKED: begin
               if (hold_vld)     state_q <= ST_LOCKED;
               else if (win_vld) state_q <= ST_GRANT;
               else              state_q <= ST_IDLE;
            end
`endif
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign gnt_o  = gnt_q;
   assign load_o = load_q;
   assign d_o    = d_q;
   assign busy_o = busy_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed requester vectors feed an expected-grant queue.
// A negedge monitor pops and compares whenever a grant is presented.
// Direct checks cover reset, async reset mid-grant, D hold and register-file contents.
module tb_rf_write_arbiter;

   logic         clk  = 1'b0;
   logic         rst  = 1'b1;
   logic [3:0]   req  = '0;
   logic [3:0]   lock = '0;
   logic [19:0]  addr = '0;
   logic [127:0] data = '0;
   logic [3:0]   gnt;
   logic [31:0]  load;
   logic [31:0]  d;
   logic         busy;

   typedef struct packed {
      logic [3:0]  gnt;
      logic [31:0] load;
      logic [31:0] d;
      logic        busy;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] rf [32];

   rf_write_arbiter #(
      .NUM_REQ(4), .DATA_WIDTH(32), .ADDR_WIDTH(5), .MAX_BURST(4)
   ) dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .data_i(data),
      .lock_i(lock), .gnt_o(gnt), .load_o(load), .d_o(d), .busy_o(busy)
   );

   always #5 clk = ~clk;

   // Register-file model driven by the arbiter's write controls.
   always @(posedge clk) begin
      for (int i = 0; i < 32; i++) begin
         if (load[i]) rf[i] <= d;
      end
   end

   task automatic set_rq(input int i, input logic [4:0] a, input logic [31:0] dv);
      addr[i*5 +: 5]   = a;
      data[i*32 +: 32] = dv;
   endtask

   task automatic push(input logic [3:0] g, input logic [31:0] l, input logic [31:0] dv, input logic b);
      exp_t e;
      e.gnt  = g;
      e.load = l;
      e.d    = dv;
      e.busy = b;
      exp_q.push_back(e);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp_v);
      end
   endtask

   // Monitor: one-hot invariants every cycle, scoreboard compare on every grant.
   always @(negedge clk) begin
      if (!rst) begin
         checks++;
         if ($countones(gnt) > 1 || $countones(load) > 1) begin
            errors++;
            $display("FAIL onehot gnt=%b load=%h", gnt, load);
         end
         if (gnt != 4'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_grant gnt=%b load=%h d=%h busy=%b", gnt, load, d, busy);
            end else begin
               mon_e = exp_q.pop_front();
               if (gnt !== mon_e.gnt || load !== mon_e.load || d !== mon_e.d || busy !== mon_e.busy) begin
                  errors++;
                  $display("FAIL grant actual gnt=%b load=%h d=%h busy=%b required gnt=%b load=%h d=%h busy=%b",
                           gnt, load, d, busy, mon_e.gnt, mon_e.load, mon_e.d, mon_e.busy);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = '0;
      #12;
      chk("reset_gnt", {28'b0, gnt}, 32'h0);
      chk("reset_load", load, 32'h0);
      chk("reset_d", d, 32'h0);
      chk("reset_busy", {31'b0, busy}, 32'h0);
      rst = 1'b0;

      // Four requesters; first grant goes to req0, then an async reset mid-grant.
      set_rq(0, 5'd1, 32'h1000_0000);
      set_rq(1, 5'd2, 32'h1000_0001);
      set_rq(2, 5'd3, 32'h1000_0002);
      set_rq(3, 5'd4, 32'h1000_0003);
      req = 4'b1111;
      push(4'b0001, 32'h0000_0002, 32'h1000_0000, 1'b1);
      @(posedge clk);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_gnt", {28'b0, gnt}, 32'h0);
      chk("async_rst_load", load, 32'h0);
      chk("async_rst_d", d, 32'h0);
      chk("async_rst_busy", {31'b0, busy}, 32'h0);
      @(negedge clk);
      #1;
      rst = 1'b0;

      // Round robin 0,1,2,3 after reset, each requester dropping after its grant.
      push(4'b0001, 32'h0000_0002, 32'h1000_0000, 1'b1);
      push(4'b0010, 32'h0000_0004, 32'h1000_0001, 1'b1);
      push(4'b0100, 32'h0000_0008, 32'h1000_0002, 1'b1);
      push(4'b1000, 32'h0000_0010, 32'h1000_0003, 1'b0);
      cyc();
      for (int j = 0; j < 4; j++) begin
         cyc();
         req[j] = 1'b0;
      end
      chk("idle_gnt", {28'b0, gnt}, 32'h0);
      chk("idle_load", load, 32'h0);
      chk("idle_d_hold", d, 32'h1000_0003);

      // Single write to R7.
      set_rq(2, 5'd7, 32'hDEAD_BEEF);
      req = 4'b0100;
      push(4'b0100, 32'h0000_0080, 32'hDEAD_BEEF, 1'b0);
      cyc();
      cyc();
      req = 4'b0000;
      chk("stale_req_masked", {28'b0, gnt}, 32'h0);
      chk("rf7_written", rf[7], 32'hDEAD_BEEF);

      // Write to R0: grant issued, no load strobe.
      set_rq(1, 5'd0, 32'hFFFF_FFFF);
      req = 4'b0010;
      push(4'b0010, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0);
      cyc();
      cyc();
      req = 4'b0000;
      chk("rf0_zero", rf[0], 32'h0);

      // req0 re-requests continuously, req3 once: req3 must not starve.
      set_rq(0, 5'd9, 32'hAAAA_0000);
      set_rq(3, 5'd31, 32'h3333_3333);
      req = 4'b1001;
      push(4'b1000, 32'h8000_0000, 32'h3333_3333, 1'b1);
      push(4'b0001, 32'h0000_0200, 32'hAAAA_0000, 1'b0);
      push(4'b0001, 32'h0000_0200, 32'hAAAA_0000, 1'b0);
      cyc();
      cyc();
      req[3] = 1'b0;
      cyc();
      cyc();
      cyc();
      req[0] = 1'b0;
      chk("rf31_written", rf[31], 32'h3333_3333);

      // req1 with LOCK against waiting req2.
      set_rq(1, 5'd12, 32'h1111_1111);
      set_rq(2, 5'd13, 32'h2222_2222);
      req  = 4'b0110;
      lock = 4'b0010;
`ifdef RF_ARB_LOCK_EN
      push(4'b0010, 32'h0000_1000, 32'h1111_1111, 1'b1);
      push(4'b0010, 32'h0000_1000, 32'h1111_1111, 1'b1);
      push(4'b0010, 32'h0000_1000, 32'h1111_1111, 1'b1);
      push(4'b0010, 32'h0000_1000, 32'h1111_1111, 1'b1);
      push(4'b0100, 32'h0000_2000, 32'h2222_2222, 1'b0);
      push(4'b0010, 32'h0000_1000, 32'h1111_1111, 1'b0);
      for (int j = 0; j < 6; j++) cyc();
`else
      push(4'b0010, 32'h0000_1000, 32'h1111_1111, 1'b1);
      push(4'b0100, 32'h0000_2000, 32'h2222_2222, 1'b0);
      push(4'b0010, 32'h0000_1000, 32'h1111_1111, 1'b0);
      push(4'b0010, 32'h0000_1000, 32'h1111_1111, 1'b0);
      cyc();
      cyc();
      cyc();
      req[2] = 1'b0;
      cyc();
      cyc();
      cyc();
`endif
      req  = 4'b0000;
      lock = 4'b0000;
      cyc();
      cyc();
      cyc();
      chk("rf13_written", rf[13], 32'h2222_2222);
      chk("queue_drained", exp_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
